// File: rtl/bullet_ram_loader_pkg.sv
// Shared sprite definitions: loader FSM states and sprite geometry.
package bullet_ram_loader_pkg;

  localparam int H_SIZE = 8;
  localparam int V_SIZE = 8;
  localparam int SPRITE_PIXELS = H_SIZE * V_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLANK,
    LOAD,
    DONE
  } ldr_state_t;

endpackage

// File: rtl/bullet_ram_loader.sv
// Streams one raster-ordered sprite into bullet RAM, writing only while
// the video pipeline is in blanking.
module bullet_ram_loader
  import bullet_ram_loader_pkg::*;
#(
  parameter int              CD        = 12,
  parameter int              ADDR      = 6,
  parameter logic [CD-1:0]   KEY_COLOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            blank,
  input  logic            s_valid,
  input  logic [CD-1:0]   s_data,
  input  logic            s_last,
  output logic            s_ready,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [CD-1:0]   din,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR:0]   opaque_cnt
);

  localparam logic [ADDR-1:0] LAST_ADDR = '1;
  localparam logic [ADDR:0]   OPQ_MAX   = {1'b1, {ADDR{1'b0}}};

  ldr_state_t      state, nxt;
  logic [ADDR-1:0] count;
  logic            hs;
  logic            at_end;
  logic            finish;

  assign s_ready = (state == LOAD) && blank;
  assign hs      = s_valid && s_ready;
  assign at_end  = (count == LAST_ADDR);
  assign finish  = hs && (s_last || at_end);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:       if (start)  nxt = WAIT_BLANK;
      WAIT_BLANK: if (blank)  nxt = LOAD;
      LOAD:       if (finish) nxt = DONE;
      DONE:                   nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= '0;
      we         <= 1'b0;
      addr_w     <= '0;
      din        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      opaque_cnt <= '0;
    end else begin
      we   <= hs;
      done <= (state == DONE);
      if (state == IDLE && start) begin
        count      <= '0;
        err        <= 1'b0;
        opaque_cnt <= '0;
      end
      if (hs) begin
        addr_w <= count;
        din    <= s_data;
        // Counter stops at the final address so it never wraps.
        if (!finish) count <= count + 1'b1;
        if (finish) err <= !(at_end && s_last);
        if (s_data != KEY_COLOR && opaque_cnt != OPQ_MAX)
          opaque_cnt <= opaque_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bullet_ram_loader.sv
// Scoreboard bench for bullet_ram_loader: expected writes queued at
// each accepted pixel and matched against the RAM write port.
module tb_bullet_ram_loader;

  localparam int CD   = 12;
  localparam int ADDR = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            blank;
  logic            s_valid;
  logic [CD-1:0]   s_data;
  logic            s_last;
  logic            s_ready;
  logic            we;
  logic [ADDR-1:0] addr_w;
  logic [CD-1:0]   din;
  logic            busy;
  logic            done;
  logic            err;
  logic [ADDR:0]   opaque_cnt;

  int checks   = 0;
  int failures = 0;
  logic [ADDR+CD-1:0] sb[$];

  bullet_ram_loader #(.CD(CD), .ADDR(ADDR), .KEY_COLOR('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blank(blank),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .we(we), .addr_w(addr_w), .din(din),
    .busy(busy), .done(done), .err(err), .opaque_cnt(opaque_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_we", 32'(addr_w), 32'hFFFF_FFFF);
      end else begin
        logic [ADDR+CD-1:0] e;
        e = sb.pop_front();
        chk("wr_addr", 32'(addr_w), 32'(e[ADDR+CD-1:CD]));
        chk("wr_data", 32'(din), 32'(e[CD-1:0]));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int last_idx, input int mode,
                      input int gap_at, input int start_at,
                      output int opq);
    logic [CD-1:0] d;
    opq = 0;
    for (int i = 0; i < n; i++) begin
      int k;
      if (mode == 0) d = CD'(i);
      else d = (i % 4 == 0) ? '0 : CD'($urandom_range(1, 4095));
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == last_idx);
      start   = (i == start_at);
      if (i == gap_at) begin
        blank = 1'b0;
        for (int g = 0; g < 100; g++) begin
          @(negedge clk);
          chk("gap_ready", 32'(s_ready), 32'd0);
          if (g > 0) chk("gap_we", 32'(we), 32'd0);
          @(posedge clk); #1;
          start = 1'b0;
        end
        blank = 1'b1;
      end
      k = 0;
      while (1) begin
        @(negedge clk);
        if (s_ready) break;
        k++;
        if (k > 500) begin
          chk("ready_timeout", 32'(s_ready), 32'd1);
          break;
        end
      end
      sb.push_back({ADDR'(i), d});
      if (d != '0) opq++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_done(input string tag, input int exp_err,
                            input int exp_opq);
    @(negedge clk);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_opq"}, 32'(opaque_cnt), 32'(exp_opq));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int opq;
    rst_n = 1'b0; start = 1'b0; blank = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr_w), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_opq", 32'(opaque_cnt), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full load, starting outside blanking to exercise WAIT_BLANK.
    s_valid = 1'b1;
    pulse_start();
    repeat (3) begin
      @(negedge clk);
      chk("wb_busy", 32'(busy), 32'd1);
      chk("wb_ready", 32'(s_ready), 32'd0);
      chk("wb_we", 32'(we), 32'd0);
    end
    @(posedge clk); #1;
    blank = 1'b1;
    feed(64, 63, 0, -1, -1, opq);
    check_done("full", 0, 63);

    // Blank drops after 20 pixels.
    pulse_start();
    feed(64, 63, 1, 20, -1, opq);
    check_done("gap", 0, opq);

    // Short frame.
    pulse_start();
    feed(10, 9, 1, -1, -1, opq);
    check_done("short", 1, opq);

    // Missing last.
    pulse_start();
    feed(64, -1, 1, -1, -1, opq);
    check_done("nolast", 1, opq);
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nolast_ready", 32'(s_ready), 32'd0);
      chk("nolast_we", 32'(we), 32'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;

    // Start while busy.
    pulse_start();
    feed(64, 63, 0, -1, 30, opq);
    check_done("restart", 0, 63);
    repeat (2) begin
      @(negedge clk);
      chk("restart_idle", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;

    // Reset mid-load.
    pulse_start();
    feed(30, -1, 0, -1, -1, opq);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_opq", 32'(opaque_cnt), 32'd0);
    chk("mid_rst_sb", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    pulse_start();
    feed(64, 63, 0, -1, -1, opq);
    check_done("post_rst", 0, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 32'd1, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bullet_ram_loader.md
BULLET_RAM_LOADER -- requirements
Module: bullet_ram_loader

Interface
REQ-001 Parameters SHALL be: CD, default 12, colour depth; ADDR, default 6, sprite RAM address bits; KEY_COLOR, default 0, chroma key value.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  single-cycle request to begin one sprite load.
REQ-005 blank  input  1  high while the video pipeline does not read sprite RAM; RAM writes SHALL occur only while it is high.
REQ-006 s_valid  input  1  source pixel valid.
REQ-007 s_data  input  CD  source pixel, raster order: row-major, x fastest.
REQ-008 s_last  input  1  marks the source's final pixel.
REQ-009 s_ready  output  1  loader accepts a pixel this cycle.
REQ-010 we  output  1  sprite RAM write enable.
REQ-011 addr_w  output  ADDR  sprite RAM write address {row[2:0], col[2:0]}.
REQ-012 din  output  CD  sprite RAM write data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a load ends.
REQ-015 err  output  1  length error flag for the last load.
REQ-016 opaque_cnt  output  ADDR+1  count of pixels not equal to KEY_COLOR in the last load.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_BLANK, LOAD and DONE.
REQ-018 In IDLE, start=1 SHALL move to WAIT_BLANK and clear the pixel counter, err and opaque_cnt.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 WAIT_BLANK SHALL move to LOAD on the first cycle with blank=1.
REQ-021 In LOAD, s_ready SHALL equal blank; in all other states s_ready SHALL be 0.
REQ-022 A handshake (s_valid & s_ready) SHALL register we=1, addr_w=count and din=s_data for exactly the next cycle, then increment count by 1.
REQ-023 Outside handshakes, we SHALL be 0 and addr_w/din SHALL hold their last values.
REQ-024 If blank falls mid-load, LOAD SHALL pause, with no state change and no count change, and SHALL resume when blank rises.
REQ-025 Each handshake with s_data != KEY_COLOR SHALL increment opaque_cnt; the maximum value is 2^ADDR, which SHALL NOT wrap.
REQ-026 A handshake at count = 2^ADDR-1 SHALL move to DONE, and SHALL set err if s_last=0.
REQ-027 A handshake with s_last=1 at count < 2^ADDR-1 SHALL set err and move to DONE; the remaining RAM entries SHALL be left unwritten.
REQ-028 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-029 err and opaque_cnt SHALL hold their values until the next accepted start.
REQ-030 The counter SHALL be ADDR bits; an ADDR-bit wrap SHALL never occur, because LOAD exits at the final address.

Reset
REQ-031 With rst_n=0 at a clock edge: state=IDLE; count=0; we=0; addr_w=0; din=0; done=0; err=0; opaque_cnt=0; busy=0; s_ready=0.
REQ-032 Reset mid-load SHALL abandon the load immediately with no further write; partially written RAM contents are not restored.

Structure
REQ-033 The FSM state enum and the sprite geometry constants (H_SIZE=8, V_SIZE=8) SHALL live in a shared sprite package that the sprite source blocks also import.
REQ-034 The block SHALL be a single module with no sub-modules; it drives the write port of bullet_ram in the parent.

Verification
REQ-035 Full load: start, blank=1, 64 back-to-back pixels with data = index and s_last on the 64th -> 64 writes at addr 0..63, din = index, done pulse one cycle after the final we, err=0, opaque_cnt=63.
REQ-036 Blank gating: drop blank after pixel 20 for 100 cycles -> s_ready=0 and no we during the gap; writes resume at addr 20; final count is still 64.
REQ-037 Short frame: s_last on the 10th pixel -> writes at addr 0..9 only, err=1, done pulses, return to IDLE.
REQ-038 Missing last: 64 pixels with s_last=0 -> err=1, done pulses, s_ready=0 afterwards.
REQ-039 Start while busy: second start pulse mid-load -> ignored, load completes normally.
REQ-040 Reset mid-load: rst_n=0 after 30 writes -> next cycle we=0, busy=0, opaque_cnt=0; a subsequent start performs a clean full load from addr 0.
